gray_ptr_rx: RTL
================

GRAY_PTR_RX -- requirements
Module: gray_ptr_rx

Interface
REQ-001 Parameter N, default 8: width of the gray-coded pointer and all count outputs; legal range 2..32.
REQ-002 clk_i  input  1  single clock; all state on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 gray_i  input  N  gray-coded forward-counting pointer from the transmitting side.
REQ-005 bin_o  output  N  registered binary value of the last accepted pointer.
REQ-006 delta_valid_o  output  1  accumulated forward advance is non-zero.
REQ-007 delta_ready_i  input  1  consumer accepts delta_o this cycle.
REQ-008 delta_o  output  N  number of forward steps accumulated since the last handshake.
REQ-009 err_o  output  1  sticky protocol error flag.
REQ-010 err_clr_i  input  1  clears err_o.

Function
REQ-011 The input SHALL pass through one capture register g_q; all decisions use g_q against the stored reference g_ref.
REQ-012 FSM states: UNPRIMED (after reset) and TRACK.
REQ-013 UNPRIMED: on the first edge with g_q valid after reset, g_ref and bin_o SHALL load g_q and its decoded value, with no delta and no error, then go to TRACK.
REQ-014 TRACK, g_q == g_ref: no change.
REQ-015 TRACK, legal step (exactly one bit differs and decode(g_q) == bin_o+1 mod 2^N): g_ref and bin_o update, and the accumulator increments by 1.
REQ-016 Wrap-around: bin_o 2^N-1 -> 0 SHALL be a legal step.
REQ-017 TRACK, any other change (more than one bit, or a backward step) SHALL set err_o, and g_ref/bin_o SHALL resynchronise to g_q with no accumulator change.
REQ-018 Latency: a gray_i change SHALL be reflected in bin_o and delta_valid_o 2 clocks later.
REQ-019 delta_valid_o = (acc != 0); delta_o = acc.
REQ-020 A handshake occurs when delta_valid_o && delta_ready_i; acc SHALL then load 0, or 1 if a legal step is accepted in the same cycle.
REQ-021 Overflow: a legal step with acc == 2^N-1 and no handshake in that cycle SHALL hold acc saturated and set err_o.
REQ-022 delta_o and delta_valid_o SHALL remain stable while valid and not ready, except for increments from new steps.
REQ-023 err_clr_i clears err_o; a new error in the same cycle as err_clr_i SHALL leave err_o = 1.

Reset
REQ-024 Reset SHALL set g_q = 0, g_ref = 0, bin_o = 0, acc = 0 (so delta_valid_o = 0 and delta_o = 0), err_o = 0, and state = UNPRIMED.
REQ-025 Reset asserted mid-operation SHALL discard pending delta immediately and re-prime on the first sample after release.

Configuration
REQ-026 Macro GRAY_PTR_RX_SYNC_EN, when defined, SHALL insert a 2-flop synchroniser ahead of g_q, giving a REQ-018 latency of 4 clocks.
REQ-027 Synchroniser flops SHALL reset to 0.
REQ-028 Without GRAY_PTR_RX_SYNC_EN, gray_i feeds g_q directly.

Structure
REQ-029 Package gray_ptr_rx_pkg SHALL hold the FSM state enum typedef (UNPRIMED, TRACK) and the default width constant.
REQ-030 Gray decoding SHALL use one instance of the existing gray_to_binary converter on g_q; no other sub-modules.

Verification (N=4, macro off unless stated)
REQ-031 Reset release with gray_i = 4'b0110 -> bin_o = 4 two clocks later; delta_valid_o = 0; err_o = 0.
REQ-032 gray_i stepped 0000->0001->0011->0010 with ready held low -> delta_o = 3, bin_o = 3; then pulse ready -> delta_o = 0.
REQ-033 Step 15 -> 0 (gray 1000->0000) -> legal, acc += 1, err_o = 0.
REQ-034 Jump gray 0001 -> 0111 -> err_o = 1, bin_o = 5, acc unchanged; err_clr_i pulse -> err_o = 0.
REQ-035 Hold ready low through 16 legal steps -> acc saturates at 15 and err_o = 1; handshake in the same cycle as a step -> acc = 1.
REQ-036 With GRAY_PTR_RX_SYNC_EN defined: single step -> bin_o updates 4 clocks after gray_i changes.

Source files
------------

// File: rtl/gray_ptr_rx_pkg.sv
// gray_ptr_rx_pkg: shared types and constants for the gray pointer receiver.
// Holds the FSM state enum and the default pointer width.
package gray_ptr_rx_pkg;

  localparam int unsigned GPR_N_DEF = 8;

  typedef enum logic {
    UNPRIMED = 1'b0,
    TRACK    = 1'b1
  } gpr_state_e;

endpackage

// File: rtl/gray_ptr_rx_g2b.sv
// gray_to_binary: combinational gray-code to binary converter.
// Ports: gray_i (N) gray input, bin_o (N) binary output.
module gray_to_binary #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] gray_i,
  output logic [N-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    bin_o[N-1] = gray_i[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      bin_o[i] = bin_o[i+1] ^ gray_i[i];
    end
  end

endmodule

// File: rtl/gray_ptr_rx.sv
// gray_ptr_rx: receives a gray-coded forward pointer, tracks its binary
// value and accumulates forward steps for a valid/ready consumer.
// Ports: clk_i, rst_i (async, active-high), gray_i (N) pointer in,
//   bin_o (N) last accepted pointer, delta_valid_o/delta_ready_i/delta_o
//   (N) step-count handshake, err_o sticky error, err_clr_i clears it.
// Option: define GRAY_PTR_RX_SYNC_EN to add a 2-flop synchroniser on gray_i.
module gray_ptr_rx
  import gray_ptr_rx_pkg::*;
#(
  parameter int unsigned N = GPR_N_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] gray_i,
  output logic [N-1:0] bin_o,
  output logic         delta_valid_o,
  input  logic         delta_ready_i,
  output logic [N-1:0] delta_o,
  output logic         err_o,
  input  logic         err_clr_i
);

  logic [N-1:0] g_in;
  logic         g_in_vld;

`ifdef GRAY_PTR_RX_SYNC_EN
  logic [N-1:0] s1_q;
  logic [N-1:0] s2_q;
  logic [1:0]   sv_q;

  // sv_q marks when s2_q holds a real sample rather than reset fill.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
      sv_q <= '0;
    end else begin
      s1_q <= gray_i;
      s2_q <= s1_q;
      sv_q <= {sv_q[0], 1'b1};
    end
  end

  assign g_in     = s2_q;
  assign g_in_vld = sv_q[1];
`else
  assign g_in     = gray_i;
  assign g_in_vld = 1'b1;
`endif

  gpr_state_e   state_q;
  logic [N-1:0] g_q;
  logic         g_vld_q;
  logic [N-1:0] g_ref_q;
  logic [N-1:0] bin_q;
  logic [N-1:0] acc_q;
  logic         err_q;

  logic [N-1:0] dec;
  logic [N-1:0] g_diff;
  logic         one_bit;
  logic         step_ok;
  logic         bad;
  logic         hs;
  logic         ovf;
  logic [N-1:0] acc_d;
  logic         err_d;

  gray_to_binary #(.N(N)) u_g2b (
    .gray_i (g_q),
    .bin_o  (dec)
  );

  assign g_diff  = g_q ^ g_ref_q;
  assign one_bit = (g_diff != '0) &&
                   ((g_diff & (g_diff - N'(1))) == '0);

  always_comb begin
    step_ok = (state_q == TRACK) && g_vld_q &&
              one_bit && (dec == bin_q + N'(1));
    bad     = (state_q == TRACK) && g_vld_q &&
              (g_q != g_ref_q) && !step_ok;
    hs      = (acc_q != '0) && delta_ready_i;
    ovf     = step_ok && !hs && (acc_q == '1);
    acc_d   = acc_q;
    if (hs) begin
      acc_d = step_ok ? N'(1) : '0;
    end else if (step_ok && !ovf) begin
      acc_d = acc_q + N'(1);
    end
    // A fresh error wins over a simultaneous clear.
    err_d = bad || ovf || (err_q && !err_clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= UNPRIMED;
      g_q     <= '0;
      g_vld_q <= 1'b0;
      g_ref_q <= '0;
      bin_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      g_q     <= g_in;
      g_vld_q <= g_in_vld;
      acc_q   <= acc_d;
      err_q   <= err_d;
      unique case (state_q)
        UNPRIMED: begin
          if (g_vld_q) begin
            g_ref_q <= g_q;
            bin_q   <= dec;
            state_q <= TRACK;
          end
        end
        TRACK: begin
          // Legal steps and errors both adopt the new sample.
          if (step_ok || bad) begin
            g_ref_q <= g_q;
            bin_q   <= dec;
          end
        end
        default: state_q <= UNPRIMED;
      endcase
    end
  end

  assign bin_o         = bin_q;
  assign delta_o       = acc_q;
  assign delta_valid_o = (acc_q != '0);
  assign err_o         = err_q;

endmodule
